proj_arbiter: RTL and testbench

Round-robin arbiter that shares one projection unit (`<B,A>A`, four 16-bit lanes, start/done handshake) among N_REQ requesters in the ZF detector's Gram-Schmidt/QR stage. It accepts one request at a time and holds that request's operands stable for the whole operation. It pulses the unit's start, waits for done and returns the 64-bit result to the owning requester. A watchdog reports a hung unit as an error response.

---
 rtl/proj_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_proj_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_arbiter.sv
// Round-robin arbiter sharing one <B,A>A projection unit among N_REQ requesters.
// One operation at a time: grant, pulse start, wait for done (or watchdog), respond.
module proj_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [64*N_REQ-1:0]   req_a,
  input  logic [64*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [63:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  proj_start,
  output logic [63:0]           proj_a,
  output logic [63:0]           proj_b,
  input  logic                  proj_done,
  input  logic [63:0]           proj_result
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned SUM_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   gnt_d;
  logic [N_REQ-1:0]   rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_d;
  logic               rsp_err_d;
  logic               busy_d;
  logic               proj_start_d;
  logic [DATA_W-1:0]  proj_a_d;
  logic [DATA_W-1:0]  proj_b_d;

  logic [SUM_W-1:0]   pick;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               grant_ok;

  // First requester found scanning ptr, ptr+1, ... with wrap; MSB flags a hit.
  function automatic logic [SUM_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [SUM_W-1:0] cand;
    logic             found;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, p} + SUM_W'(i);
      if (cand >= SUM_W'(N_REQ)) begin
        cand = cand - SUM_W'(N_REQ);
      end
      if (!found && r[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
    return {found, idx};
  endfunction

  // Successor index modulo N_REQ (N_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    logic [SUM_W-1:0] n;
    n = {1'b0, idx} + SUM_W'(1);
    if (n == SUM_W'(N_REQ)) begin
      n = '0;
    end
    return n[IDX_W-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // Round-robin winner among the currently sampled requests.
  always_comb begin
    pick      = rr_pick(req, ptr_q);
    win_found = pick[SUM_W-1];
    win_idx   = pick[IDX_W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and next output values; a grant may follow a successful response.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data;
    rsp_err_d    = rsp_err;
    proj_start_d = 1'b0;
    proj_a_d     = proj_a;
    proj_b_d     = proj_b;
    grant_ok     = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_ok = 1'b1;
      end
      S_START: begin
        // A done seen here belongs to nothing we issued; ignore it.
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (proj_done) begin
          rsp_data_d  = proj_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = to_onehot(owner_q);
          state_d     = S_IDLE;
          grant_ok    = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Hung unit: error response, no re-grant on this edge.
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = to_onehot(owner_q);
          state_d     = S_IDLE;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (grant_ok && win_found) begin
      state_d      = S_START;
      owner_d      = win_idx;
      ptr_d        = next_idx(win_idx);
      gnt_d        = to_onehot(win_idx);
      proj_start_d = 1'b1;
      proj_a_d     = req_a[DATA_W*win_idx +: DATA_W];
      proj_b_d     = req_b[DATA_W*win_idx +: DATA_W];
    end

    busy_d = (state_d != S_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      proj_start <= 1'b0;
      proj_a     <= '0;
      proj_b     <= '0;
    end else begin
      gnt        <= gnt_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_err    <= rsp_err_d;
      busy       <= busy_d;
      proj_start <= proj_start_d;
      proj_a     <= proj_a_d;
      proj_b     <= proj_b_d;
    end
  end

endmodule

// File: tb/tb_proj_arbiter.sv
// Bench for proj_arbiter: directed table, corner sequences, randomized traffic
// against a transaction-level reference model.
module tb_proj_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [N-1:0]      req;
  logic [64*N-1:0]   req_a, req_b;
  logic [N-1:0]      gnt, rsp_valid;
  logic [63:0]       rsp_data;
  logic              rsp_err, busy, proj_start;
  logic [63:0]       proj_a, proj_b;
  logic              proj_done;
  logic [63:0]       proj_result;

  always #5 clk = ~clk;

  proj_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .proj_start(proj_start), .proj_a(proj_a), .proj_b(proj_b),
    .proj_done(proj_done), .proj_result(proj_result)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  // Requesters
  logic [N-1:0] pend = '0;
  bit           hold_req = 1'b0;
  logic [63:0]  op_a [N];
  logic [63:0]  op_b [N];

  // Projection unit model: returns A^B, lat cycles after the start cycle (0 = never)
  int          lat = 6;
  int          done_cycle = -1;
  logic [63:0] unit_res = '0;

  // Reference model
  bit          m_active;
  int          m_t;
  int          m_owner;
  int          m_ptr;
  logic [N-1:0] e_gnt, e_rv;
  logic [63:0] e_data, e_a, e_b;
  logic        e_err, e_start;

  // Event logs
  int   g_cyc[$];
  int   g_idx[$];
  int   r_cyc[$];
  int   r_idx[$];
  logic r_err[$];
  logic [63:0] r_data[$];

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] rv;
    logic         start;
    logic         busy;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] g,
                              input logic [N-1:0] v, input logic s, input logic b);
    vec_t x;
    x.req = r; x.gnt = g; x.rv = v; x.start = s; x.busy = b;
    return x;
  endfunction

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_t = 0; m_ptr = 0; m_owner = 0;
    e_gnt = '0; e_rv = '0; e_data = '0; e_a = '0; e_b = '0; e_err = 1'b0; e_start = 1'b0;
  endtask

  // One clock edge of the arbiter's rules, using cycles-since-grant as the timer.
  task automatic model_step();
    bit try_g;
    int w;
    try_g = 1'b0;
    e_gnt = '0; e_rv = '0; e_start = 1'b0;
    if (!m_active) try_g = 1'b1;
    else if (m_t == 0) m_t = 1;
    else if (proj_done) begin
      e_rv[m_owner] = 1'b1; e_data = proj_result; e_err = 1'b0;
      m_active = 1'b0; try_g = 1'b1;
    end else if (m_t == int'(TO)) begin
      e_rv[m_owner] = 1'b1; e_data = '0; e_err = 1'b1;
      m_active = 1'b0;
    end else m_t++;
    if (try_g && req != '0) begin
      w = -1;
      for (int k = 0; k < int'(N); k++)
        if (w < 0 && req[(m_ptr + k) % int'(N)]) w = (m_ptr + k) % int'(N);
      e_gnt[w] = 1'b1; e_start = 1'b1;
      e_a = req_a[64*w +: 64]; e_b = req_b[64*w +: 64];
      m_owner = w; m_ptr = (w + 1) % int'(N);
      m_active = 1'b1; m_t = 0;
    end
  endtask

  task automatic check_outputs();
    check("gnt",        64'(gnt),        64'(e_gnt));
    check("rsp_valid",  64'(rsp_valid),  64'(e_rv));
    check("rsp_data",   rsp_data,        e_data);
    check("rsp_err",    64'(rsp_err),    64'(e_err));
    check("busy",       64'(busy),       64'(m_active));
    check("proj_start", 64'(proj_start), 64'(e_start));
    check("proj_a",     proj_a,          e_a);
    check("proj_b",     proj_b,          e_b);
  endtask

  // Drive one cycle of inputs, advance one edge, check at the falling edge.
  task automatic tick();
    req = pend;
    for (int i = 0; i < int'(N); i++) begin
      req_a[64*i +: 64] = op_a[i];
      req_b[64*i +: 64] = op_b[i];
    end
    proj_done   = reset_n && (cyc == done_cycle);
    proj_result = proj_done ? unit_res : {$urandom, $urandom};
    @(posedge clk);
    if (reset_n) model_step(); else model_reset();
    cyc++;
    @(negedge clk);
    check_outputs();
    if (gnt != '0) begin g_cyc.push_back(cyc); g_idx.push_back(first_set(gnt)); end
    if (rsp_valid != '0) begin
      r_cyc.push_back(cyc); r_idx.push_back(first_set(rsp_valid));
      r_err.push_back(rsp_err); r_data.push_back(rsp_data);
    end
    if (!reset_n) done_cycle = -1;
    else if (proj_start) begin
      unit_res   = proj_a ^ proj_b;
      done_cycle = (lat == 0) ? -1 : cyc + lat;
    end
    if (!hold_req) pend = pend & ~gnt;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    g_cyc.delete(); g_idx.delete(); r_cyc.delete(); r_idx.delete();
    r_err.delete(); r_data.delete();
  endtask

  // Reset applied between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    check("rst_gnt",        64'(gnt),        64'd0);
    check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
    check("rst_rsp_data",   rsp_data,        64'd0);
    check("rst_rsp_err",    64'(rsp_err),    64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_proj_start", 64'(proj_start), 64'd0);
    check("rst_proj_a",     proj_a,          64'd0);
    check("rst_proj_b",     proj_b,          64'd0);
    model_reset();
    done_cycle = -1;
    ticks(n);
    reset_n = 1'b1;
  endtask

  function automatic int count_in(input int q[$], input int v);
    int c = 0;
    foreach (q[i]) if (q[i] == v) c++;
    return c;
  endfunction

  initial begin
    int exp_rr [5];
    int rr_n;
    for (int i = 0; i < int'(N); i++) begin op_a[i] = '0; op_b[i] = '0; end
    req = '0; req_a = '0; req_b = '0; proj_done = 1'b0; proj_result = '0;
    model_reset();
    #2;
    do_reset(2);

    // Single request from requester 2, checked against a fixed table.
    tbl[0] = mk(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) tbl[i] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    tbl[7] = mk(4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);
    tbl[8] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    op_a[2] = 64'h0100_0200_0300_0400;
    op_b[2] = 64'h0001_0002_0003_0004;
    lat = 6; hold_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pend = tbl[i].req;
      tick();
      check("tbl_gnt",   64'(gnt),        64'(tbl[i].gnt));
      check("tbl_rv",    64'(rsp_valid),  64'(tbl[i].rv));
      check("tbl_start", 64'(proj_start), 64'(tbl[i].start));
      check("tbl_busy",  64'(busy),       64'(tbl[i].busy));
      if (i == 7) begin
        check("tbl_data", rsp_data, 64'h0101_0202_0303_0404);
        check("tbl_err",  64'(rsp_err), 64'd0);
      end
    end

    // Round robin with all four requesting continuously.
    do_reset(1);
    for (int i = 0; i < int'(N); i++) begin
      op_a[i] = {$urandom, $urandom}; op_b[i] = {$urandom, $urandom};
    end
    clear_logs();
    hold_req = 1'b1; pend = 4'b1111;
    for (int i = 0; i < 60 && g_idx.size() < 5; i++) tick();
    pend = '0;
    ticks(10);
    exp_rr = '{0, 1, 2, 3, 0};
    check("rr_count", 64'(g_idx.size() >= 5), 64'd1);
    rr_n = (g_idx.size() < 5) ? g_idx.size() : 5;
    for (int k = 0; k < rr_n; k++) begin
      check("rr_order", 64'(g_idx[k]), 64'(exp_rr[k]));
      if (k > 0) begin
        check("rr_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'd7);
        if (r_cyc.size() >= k) check("rr_gnt_with_rsp", 64'(g_cyc[k]), 64'(r_cyc[k-1]));
      end
    end

    // Rotation after a partial set: serve 1 (ptr -> 2), then 0 and 1 request.
    do_reset(1);
    hold_req = 1'b0; pend = 4'b0010;
    ticks(10);
    clear_logs();
    pend = 4'b0011;
    ticks(20);
    check("rot_count", 64'(g_idx.size()), 64'd2);
    if (g_idx.size() >= 2) begin
      check("rot_first",  64'(g_idx[0]), 64'd0);
      check("rot_second", 64'(g_idx[1]), 64'd1);
    end

    // Withdraw: requester 3 pulses req for one cycle while the unit is busy.
    clear_logs();
    pend = 4'b0001;
    ticks(3);
    pend = pend | 4'b1000;
    tick();
    pend = pend & 4'b0111;
    ticks(12);
    check("wd_no_gnt3", 64'(count_in(g_idx, 3)), 64'd0);
    check("wd_no_rsp3", 64'(count_in(r_idx, 3)), 64'd0);
    check("wd_rsp0",    64'(count_in(r_idx, 0)), 64'd1);

    // Timeout: unit never answers requester 1; requester 2 queued behind it.
    clear_logs();
    lat = 0; pend = 4'b0010;
    tick();
    lat = 6;
    tick();
    pend = pend | 4'b0100;
    ticks(int'(TO) + 14);
    check("to_gnt_count", 64'(g_idx.size() >= 2 && r_idx.size() >= 2), 64'd1);
    if (g_idx.size() >= 2 && r_idx.size() >= 2) begin
      check("to_owner",   64'(r_idx[0]), 64'd1);
      check("to_err",     64'(r_err[0]), 64'd1);
      check("to_data",    r_data[0], 64'd0);
      check("to_latency", 64'(r_cyc[0] - g_cyc[0]), 64'(TO + 1));
      check("to_next",    64'(g_idx[1]), 64'd2);
      check("to_no_regrant", 64'(g_cyc[1] - r_cyc[0]), 64'd1);
      check("to_next_ok", 64'(r_err[1]), 64'd0);
    end

    // Reset while requester 2 is in WAIT; next arbitration restarts at ptr 0.
    pend = 4'b0100;
    ticks(4);
    do_reset(1);
    clear_logs();
    pend = 4'b1010;
    ticks(20);
    check("rst_no_rsp2", 64'(count_in(r_idx, 2)), 64'd0);
    check("rst_gnt_n",   64'(g_idx.size() >= 1), 64'd1);
    if (g_idx.size() >= 1) check("rst_ptr0", 64'(g_idx[0]), 64'd1);
    pend = '0;
    ticks(10);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          op_a[i] = {$urandom, $urandom}; op_b[i] = {$urandom, $urandom};
          pend[i] = 1'b1;
        end else if (pend[i] && $urandom_range(0, 63) == 0) begin
          pend[i] = 1'b0;
        end
      end
      r = int'($urandom_range(0, 31));
      if (r == 0) lat = 0;
      else if (r == 1) lat = 24;
      else lat = int'($urandom_range(1, 8));
      if ($urandom_range(0, 999) == 0) do_reset(1);
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
